// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: out_diff = A - B, one 4-bit lookahead slice per clock.
// A valid/ready handshake accepts operands; a valid/ack handshake returns the result and flags.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             in_clk,
    input  logic             in_reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_ready,
    output logic             out_valid,
    input  logic             in_ack,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] bn_r;
    logic [WIDTH-1:0] diff_r;
    logic [WIDTH-1:0] diff_s;
    logic [IDX_W-1:0] idx_r;
    logic             carry_r;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [3:0]       sum_s;
    logic             cout_s;
    logic             last_s;
    logic             ready_r;
    logic             ready_s;
    logic             valid_r;
    logic             valid_s;
    logic             borrow_r;
    logic             overflow_r;
    logic             zero_r;

    // 4-bit generate/propagate lookahead adder; returns {carry_out, sum}.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign last_s = (idx_r == LAST_IDX);

    // Select the active nibble, run it through the slice and splice the sum into the result.
    always_comb begin
        a_nib_s = 4'd0;
        b_nib_s = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            a_nib_s = a_nib_s | (a_r[4*i +: 4] & {4{idx_r == IDX_W'(i)}});
            b_nib_s = b_nib_s | (bn_r[4*i +: 4] & {4{idx_r == IDX_W'(i)}});
        end
        {cout_s, sum_s} = cla4(a_nib_s, b_nib_s, carry_r);
        diff_s = diff_r;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_r == IDX_W'(i)) begin
                diff_s[4*i +: 4] = sum_s;
            end else begin
                diff_s[4*i +: 4] = diff_r[4*i +: 4];
            end
        end
    end

    // State register.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a completing handshake never overlaps a new accept.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (in_ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state so they can be registered.
    always_comb begin
        ready_s = 1'b0;
        valid_s = 1'b0;
        case (state_s)
            IDLE:    ready_s = 1'b1;
            DONE:    valid_s = 1'b1;
            default: begin
                ready_s = 1'b0;
                valid_s = 1'b0;
            end
        endcase
    end

    // Handshake output registers.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            ready_r <= ready_s;
            valid_r <= valid_s;
        end
    end

    // Operand capture, per-nibble accumulation and flag registration.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            a_r        <= {WIDTH{1'b0}};
            bn_r       <= {WIDTH{1'b0}};
            diff_r     <= {WIDTH{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            carry_r    <= 1'b0;
            borrow_r   <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        bn_r    <= ~in_b;
                        carry_r <= 1'b1;
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    diff_r  <= diff_s;
                    carry_r <= cout_s;
                    if (last_s) begin
                        borrow_r   <= ~cout_s;
                        // bn_r holds ~B, so equal MSBs mean A and B have opposite signs.
                        overflow_r <= (a_r[WIDTH-1] == bn_r[WIDTH-1]) & (sum_s[3] != a_r[WIDTH-1]);
                        zero_r     <= (diff_s == {WIDTH{1'b0}});
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    carry_r <= carry_r;
                end
            endcase
        end
    end

    assign out_ready    = ready_r;
    assign out_valid    = valid_r;
    assign out_diff     = diff_r;
    assign out_borrow   = borrow_r;
    assign out_overflow = overflow_r;
    assign out_zero     = zero_r;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor: directed scenarios on a 16-bit instance
// plus a randomized regression on 4-, 16- and 32-bit instances against an arithmetic model.
module tb_nibble_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        valid, ready, ovalid, ack, borrow, ovf, zero;
    logic [15:0] a, b, diff;
    logic        v4, r4, ov4, k4, br4, of4, z4;
    logic [3:0]  a4, b4, d4;
    logic        v32, r32, ov32, k32, br32, of32, z32;
    logic [31:0] a32, b32, d32;

    int checks = 0;
    int errors = 0;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .in_clk(clk), .in_reset(rst), .in_valid(valid), .in_a(a), .in_b(b),
        .out_ready(ready), .out_valid(ovalid), .in_ack(ack), .out_diff(diff),
        .out_borrow(borrow), .out_overflow(ovf), .out_zero(zero));

    nibble_serial_subtractor #(.WIDTH(4)) dut4 (
        .in_clk(clk), .in_reset(rst), .in_valid(v4), .in_a(a4), .in_b(b4),
        .out_ready(r4), .out_valid(ov4), .in_ack(k4), .out_diff(d4),
        .out_borrow(br4), .out_overflow(of4), .out_zero(z4));

    nibble_serial_subtractor #(.WIDTH(32)) dut32 (
        .in_clk(clk), .in_reset(rst), .in_valid(v32), .in_a(a32), .in_b(b32),
        .out_ready(r32), .out_valid(ov32), .in_ack(k32), .out_diff(d32),
        .out_borrow(br32), .out_overflow(of32), .out_zero(z32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: w-bit subtraction from integer arithmetic and signed range checks.
    task automatic model(input int w, input longint unsigned x, input longint unsigned y,
                         output longint unsigned d, output logic br, output logic ov, output logic z);
        longint half, sx, sy, sd;
        half = longint'(64'd1 << (w - 1));
        sx   = (longint'(x) >= half) ? longint'(x) - 2 * half : longint'(x);
        sy   = (longint'(y) >= half) ? longint'(y) - 2 * half : longint'(y);
        sd   = sx - sy;
        d    = (x - y) & ((64'd1 << w) - 64'd1);
        br   = (x < y);
        ov   = (sd < -half) || (sd >= half);
        z    = (d == 64'd0);
    endtask

    // Offer one operation to the 16-bit DUT and return cycles from accept to out_valid (-1 on timeout).
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, output int lat);
        int w;
        w = 0;
        while (ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        a = ta; b = tb_v; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ovalid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic ack_op();
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({ready, ovalid, diff, borrow, ovf, zero, r4, ov4, r32, ov32} !== {2'b10, 16'h0000, 3'b000, 4'b1010}) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b diff=%h flags=%b%b%b r4=%b r32=%b", ready, ovalid, diff, borrow, ovf, zero, r4, r32);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        do_op(16'h1234, 16'h0034, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 4", lat);
        end
        checks++;
        if ({diff, borrow, ovf, zero} !== {16'h1200, 3'b000}) begin
            errors++;
            $display("FAIL basic_result: got %h %b%b%b want 1200 000", diff, borrow, ovf, zero);
        end
        ack_op();
        checks++;
        if ({ovalid, ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_ack: valid=%b ready=%b want 0 1", ovalid, ready);
        end
    endtask

    task automatic test_borrow_overflow();
        int lat;
        do_op(16'h0000, 16'h0001, lat);
        checks++;
        if (lat !== 4 || {diff, borrow, ovf, zero} !== {16'hFFFF, 3'b100}) begin
            errors++;
            $display("FAIL borrow: lat=%0d got %h %b%b%b want FFFF 100", lat, diff, borrow, ovf, zero);
        end
        ack_op();
        do_op(16'h8000, 16'h0001, lat);
        checks++;
        if (lat !== 4 || {diff, borrow, ovf, zero} !== {16'h7FFF, 3'b010}) begin
            errors++;
            $display("FAIL overflow: lat=%0d got %h %b%b%b want 7FFF 010", lat, diff, borrow, ovf, zero);
        end
        ack_op();
    endtask

    task automatic test_zero_carry();
        int lat;
        do_op(16'h5555, 16'h5555, lat);
        checks++;
        if (lat !== 4 || {diff, borrow, ovf, zero} !== {16'h0000, 3'b001}) begin
            errors++;
            $display("FAIL zero: lat=%0d got %h %b%b%b want 0000 001", lat, diff, borrow, ovf, zero);
        end
        ack_op();
        do_op(16'h0F0F, 16'h00F0, lat);
        checks++;
        if (lat !== 4 || {diff, borrow, ovf, zero} !== {16'h0E1F, 3'b000}) begin
            errors++;
            $display("FAIL nibble_carry: lat=%0d got %h %b%b%b want 0E1F 000", lat, diff, borrow, ovf, zero);
        end
        ack_op();
    endtask

    task automatic test_backpressure();
        int lat;
        longint unsigned ed;
        logic eb, eo, ez;
        model(16, 64'h9000, 64'h0123, ed, eb, eo, ez);
        do_op(16'h9000, 16'h0123, lat);
        checks++;
        if (lat !== 4 || {diff, borrow, ovf, zero} !== {ed[15:0], eb, eo, ez}) begin
            errors++;
            $display("FAIL bp_result: lat=%0d got %h %b%b%b want %h %b%b%b", lat, diff, borrow, ovf, zero, ed[15:0], eb, eo, ez);
        end
        for (int k = 0; k < 10; k++) begin
            valid = (k % 2 == 0);
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({ovalid, ready, diff, borrow, ovf, zero} !== {2'b10, ed[15:0], eb, eo, ez}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b diff=%h want 1 0 %h", k, ovalid, ready, diff, ed[15:0]);
            end
        end
        valid = 1'b0;
        ack_op();
        checks++;
        if ({ovalid, ready, diff} !== {2'b01, ed[15:0]}) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b diff=%h want 0 1 %h", ovalid, ready, diff, ed[15:0]);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        bit spurious;
        a = 16'h1111; b = 16'h2222; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ready, ovalid, diff, borrow, ovf, zero} !== {2'b10, 16'h0000, 3'b000}) begin
            errors++;
            $display("FAIL midrun_reset: ready=%b valid=%b diff=%h flags=%b%b%b", ready, ovalid, diff, borrow, ovf, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        spurious = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ovalid !== 1'b0 || ready !== 1'b1) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin
            errors++;
            $display("FAIL midrun_abandon: got valid pulse or not ready after reset");
        end
        do_op(16'h0003, 16'h0005, lat);
        checks++;
        if (lat !== 4 || {diff, borrow, ovf, zero} !== {16'hFFFE, 3'b100}) begin
            errors++;
            $display("FAIL after_reset: lat=%0d got %h %b%b%b want FFFE 100", lat, diff, borrow, ovf, zero);
        end
        ack_op();
    endtask

    task automatic test_back_to_back();
        logic [15:0] qa[$], qb[$];
        int qc[$];
        int last_acc, cyc, accepts;
        longint unsigned ed;
        logic eb, eo, ez;
        last_acc = -1; cyc = 0; accepts = 0;
        valid = 1'b1; ack = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 40) valid = 1'b0;
            if (ready === 1'b1 && valid === 1'b1) begin
                qa.push_back(a); qb.push_back(b); qc.push_back(cyc + 1);
                accepts++;
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc + 1 - last_acc != 6) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d want 6", cyc + 1 - last_acc);
                    end
                end
                last_acc = cyc + 1;
            end
            @(posedge clk); #1;
            cyc++;
            a = 16'($urandom);
            b = 16'($urandom);
            if (ovalid === 1'b1) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: valid with no accepted op, diff=%h", diff);
                end else begin
                    model(16, 64'(qa[0]), 64'(qb[0]), ed, eb, eo, ez);
                    if (cyc - qc[0] != 4 || {diff, borrow, ovf, zero} !== {ed[15:0], eb, eo, ez}) begin
                        errors++;
                        $display("FAIL b2b_result: %h-%h lat=%0d got %h %b%b%b want 4 %h %b%b%b", qa[0], qb[0],
                                 cyc - qc[0], diff, borrow, ovf, zero, ed[15:0], eb, eo, ez);
                    end
                    void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
                end
            end
        end
        ack = 1'b0;
        checks++;
        if (accepts < 6 || qa.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: accepts=%0d pending=%0d want >=6 and 0", accepts, qa.size());
        end
    endtask

    task automatic test_random_widths();
        longint unsigned x4, y4, x16, y16, x32, y32, e4, e16, e32;
        logic eb4, eo4, ez4, eb16, eo16, ez16, eb32, eo32, ez32;
        bit s4, s16, s32;
        for (int n = 0; n < 30; n++) begin
            x4  = 64'($urandom_range(15, 0));  y4  = 64'($urandom_range(15, 0));
            x16 = 64'($urandom & 32'hFFFF);    y16 = 64'($urandom & 32'hFFFF);
            x32 = 64'($urandom);               y32 = 64'($urandom);
            if (n == 0) begin x32 = 64'h8000_0000; y32 = 64'h0000_0001; end
            model(4, x4, y4, e4, eb4, eo4, ez4);
            model(16, x16, y16, e16, eb16, eo16, ez16);
            model(32, x32, y32, e32, eb32, eo32, ez32);
            a4 = x4[3:0]; b4 = y4[3:0]; a = x16[15:0]; b = y16[15:0]; a32 = x32[31:0]; b32 = y32[31:0];
            v4 = 1'b1; valid = 1'b1; v32 = 1'b1;
            k4 = 1'b1; ack = 1'b1; k32 = 1'b1;
            @(posedge clk); #1;
            v4 = 1'b0; valid = 1'b0; v32 = 1'b0;
            s4 = 1'b0; s16 = 1'b0; s32 = 1'b0;
            for (int c = 1; c <= 12; c++) begin
                @(posedge clk); #1;
                if (ov4 === 1'b1 && !s4) begin
                    s4 = 1'b1; checks++;
                    if (c != 1 || {d4, br4, of4, z4} !== {e4[3:0], eb4, eo4, ez4}) begin
                        errors++;
                        $display("FAIL rand4: %h-%h lat=%0d got %h %b%b%b want 1 %h %b%b%b", x4[3:0], y4[3:0], c, d4, br4, of4, z4, e4[3:0], eb4, eo4, ez4);
                    end
                end
                if (ovalid === 1'b1 && !s16) begin
                    s16 = 1'b1; checks++;
                    if (c != 4 || {diff, borrow, ovf, zero} !== {e16[15:0], eb16, eo16, ez16}) begin
                        errors++;
                        $display("FAIL rand16: %h-%h lat=%0d got %h %b%b%b want 4 %h %b%b%b", x16[15:0], y16[15:0], c, diff, borrow, ovf, zero, e16[15:0], eb16, eo16, ez16);
                    end
                end
                if (ov32 === 1'b1 && !s32) begin
                    s32 = 1'b1; checks++;
                    if (c != 8 || {d32, br32, of32, z32} !== {e32[31:0], eb32, eo32, ez32}) begin
                        errors++;
                        $display("FAIL rand32: %h-%h lat=%0d got %h %b%b%b want 8 %h %b%b%b", x32[31:0], y32[31:0], c, d32, br32, of32, z32, e32[31:0], eb32, eo32, ez32);
                    end
                end
            end
            checks++;
            if ({s4, s16, s32} !== 3'b111) begin
                errors++;
                $display("FAIL rand_timeout: seen w4/w16/w32 = %b%b%b want 111", s4, s16, s32);
            end
            k4 = 1'b0; ack = 1'b0; k32 = 1'b0;
        end
    endtask

    initial begin
        valid = 1'b0; ack = 1'b0; a = 16'h0000; b = 16'h0000;
        v4 = 1'b0; k4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        v32 = 1'b0; k32 = 1'b0; a32 = 32'h0; b32 = 32'h0;
        test_reset();
        test_basic();
        test_borrow_overflow();
        test_zero_carry();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        test_random_widths();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
